// File: rtl/phy_rx.sv
// -----------------------------------------------------------------------------
// phy_rx : two-lane serial receiver with comma alignment and word unstriping.
//
// Each lane shifts in one bit per clk_32f edge (MSB first), hunts for the
// COM_BYTE comma, confirms alignment with SYNC_COUNT consecutive on-boundary
// commas, then packs non-comma bytes into 32-bit words (first byte -> [31:24]).
// Finished words go into a 2-entry per-lane buffer. The unstriper drains the
// buffers in strict lane 0, lane 1, lane 0, ... order and presents one word per
// valid_out pulse.
//
// Optional feature macro: PHY_RX_ERR_CNT_EN
//   When defined, the err_count port and a saturating error counter exist.
//   The counter advances on partial-word discard (comma arriving mid-word) and
//   on buffer overflow (word dropped). Without the macro the port is absent
//   and data behaviour is unchanged.
//
// Parameters
//   COM_BYTE    comma / idle character (default 8'hBC)
//   SYNC_COUNT  consecutive aligned commas needed to reach ACTIVE (default 4)
//
// Ports
//   clk_32f      in   1  bit clock, one serial bit per lane per rising edge
//   reset_L      in   1  asynchronous active-low reset
//   serial_in_0  in   1  lane 0 serial stream, MSB first
//   serial_in_1  in   1  lane 1 serial stream, MSB first
//   err_count    out  8  saturating error count (PHY_RX_ERR_CNT_EN only)
//   data_out     out 32  last reassembled word, held between valid pulses
//   valid_out    out  1  one-cycle pulse per new word on data_out
//   active_out   out  1  high while both lanes are ACTIVE
// -----------------------------------------------------------------------------
module phy_rx #(
  parameter logic [7:0] COM_BYTE   = 8'hBC,
  parameter int         SYNC_COUNT = 4
) (
  input  logic        clk_32f,
  input  logic        reset_L,
  input  logic        serial_in_0,
  input  logic        serial_in_1,
`ifdef PHY_RX_ERR_CNT_EN
  output logic [7:0]  err_count,
`endif
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active_out
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    SYNCING = 2'd1,
    ACTIVE  = 2'd2
  } lane_state_e;

  // Comma counter just wide enough to hold SYNC_COUNT.
  localparam int CW = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT + 1) : 1;
  localparam logic [CW-1:0] SYNC_TGT = CW'(SYNC_COUNT);
  // With a single required comma the first match already completes alignment.
  localparam lane_state_e FIRST_COM_STATE = (SYNC_COUNT > 1) ? SYNCING : ACTIVE;

  // Per-edge lane view
  logic          ser_s       [2];
  logic [7:0]    byte_s      [2];
  logic          boundary_s  [2];
  logic          is_com_s    [2];
  logic          word_done_s [2];
  logic [31:0]   word_s      [2];
  logic          pop_s       [2];
  logic          wr_en_s     [2];

  // Lane receiver state
  lane_state_e   state_q [2];
  lane_state_e   state_d [2];
  logic [7:0]    sr_q    [2];
  logic [7:0]    sr_d    [2];
  logic [2:0]    bit_q   [2];
  logic [2:0]    bit_d   [2];
  logic [CW-1:0] comma_q [2];
  logic [CW-1:0] comma_d [2];
  logic [1:0]    idx_q   [2];
  logic [1:0]    idx_d   [2];
  logic [23:0]   acc_q   [2];
  logic [23:0]   acc_d   [2];

  // Per-lane 2-entry word buffer
  logic [31:0]   mem_q [2][2];
  logic [31:0]   mem_d [2][2];
  logic          wr_q  [2];
  logic          wr_d  [2];
  logic          rd_q  [2];
  logic          rd_d  [2];
  logic [1:0]    cnt_q [2];
  logic [1:0]    cnt_d [2];

  // Unstriper / output stage
  logic          exp_q;
  logic          exp_d;
  logic [31:0]   data_q;
  logic [31:0]   data_d;
  logic          valid_q;
  logic          valid_d;
  logic          active_q;
  logic          active_d;
  logic          pop_any_s;
  logic [31:0]   head_s;

  // Byte seen this edge, boundary flag and comma detect for each lane.
  always_comb begin
    ser_s[0] = serial_in_0;
    ser_s[1] = serial_in_1;
    for (int l = 0; l < 2; l++) begin
      byte_s[l]     = {sr_q[l][6:0], ser_s[l]};
      boundary_s[l] = (bit_q[l] == 3'd7);
      is_com_s[l]   = (byte_s[l] == COM_BYTE);
    end
  end

  // Lane alignment FSM and byte-to-word packing.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      state_d[l]     = state_q[l];
      sr_d[l]        = byte_s[l];
      bit_d[l]       = bit_q[l] + 3'd1;
      comma_d[l]     = comma_q[l];
      idx_d[l]       = idx_q[l];
      acc_d[l]       = acc_q[l];
      word_done_s[l] = 1'b0;
      word_s[l]      = {acc_q[l], byte_s[l]};
      case (state_q[l])
        SEARCH: begin
          // Bit-by-bit hunt; a match defines the byte grid from here on.
          if (is_com_s[l]) begin
            bit_d[l]   = 3'd0;
            comma_d[l] = CW'(1);
            state_d[l] = FIRST_COM_STATE;
          end else begin
            state_d[l] = SEARCH;
          end
        end
        SYNCING: begin
          if (boundary_s[l] && is_com_s[l]) begin
            comma_d[l] = comma_q[l] + CW'(1);
            if ((comma_q[l] + CW'(1)) == SYNC_TGT) begin
              state_d[l] = ACTIVE;
            end else begin
              state_d[l] = SYNCING;
            end
          end else if (boundary_s[l]) begin
            comma_d[l] = {CW{1'b0}};
            state_d[l] = SEARCH;
          end else begin
            state_d[l] = SYNCING;
          end
        end
        ACTIVE: begin
          if (boundary_s[l] && is_com_s[l]) begin
            // Idle byte; any partially built word is abandoned.
            idx_d[l] = 2'd0;
          end else if (boundary_s[l]) begin
            acc_d[l] = {acc_q[l][15:0], byte_s[l]};
            if (idx_q[l] == 2'd3) begin
              word_done_s[l] = 1'b1;
              idx_d[l]       = 2'd0;
            end else begin
              idx_d[l] = idx_q[l] + 2'd1;
            end
          end else begin
            idx_d[l] = idx_q[l];
          end
        end
        default: begin
          state_d[l] = SEARCH;
        end
      endcase
    end
  end

  // Word buffers: pop for the expected lane, push completed words if room.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      mem_d[l][0] = mem_q[l][0];
      mem_d[l][1] = mem_q[l][1];
      pop_s[l]    = (exp_q == 1'(l)) && (cnt_q[l] != 2'd0);
      // A full buffer still accepts a word when it is popped on the same edge.
      wr_en_s[l]  = word_done_s[l] && ((cnt_q[l] != 2'd2) || pop_s[l]);
      if (wr_en_s[l]) begin
        mem_d[l][wr_q[l]] = word_s[l];
        wr_d[l]           = ~wr_q[l];
      end else begin
        wr_d[l] = wr_q[l];
      end
      if (pop_s[l]) begin
        rd_d[l] = ~rd_q[l];
      end else begin
        rd_d[l] = rd_q[l];
      end
      case ({wr_en_s[l], pop_s[l]})
        2'b10:   cnt_d[l] = cnt_q[l] + 2'd1;
        2'b01:   cnt_d[l] = cnt_q[l] - 2'd1;
        default: cnt_d[l] = cnt_q[l];
      endcase
    end
  end

  // Strict round-robin unstriper and output register next state.
  always_comb begin
    pop_any_s = pop_s[0] | pop_s[1];
    head_s    = exp_q ? mem_q[1][rd_q[1]] : mem_q[0][rd_q[0]];
    valid_d   = pop_any_s;
    active_d  = (state_q[0] == ACTIVE) && (state_q[1] == ACTIVE);
    if (pop_any_s) begin
      data_d = head_s;
      exp_d  = ~exp_q;
    end else begin
      data_d = data_q;
      exp_d  = exp_q;
    end
  end

  // Lane receiver and buffer state registers.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      for (int l = 0; l < 2; l++) begin
        state_q[l]  <= SEARCH;
        sr_q[l]     <= 8'd0;
        bit_q[l]    <= 3'd0;
        comma_q[l]  <= {CW{1'b0}};
        idx_q[l]    <= 2'd0;
        acc_q[l]    <= 24'd0;
        mem_q[l][0] <= 32'd0;
        mem_q[l][1] <= 32'd0;
        wr_q[l]     <= 1'b0;
        rd_q[l]     <= 1'b0;
        cnt_q[l]    <= 2'd0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        state_q[l]  <= state_d[l];
        sr_q[l]     <= sr_d[l];
        bit_q[l]    <= bit_d[l];
        comma_q[l]  <= comma_d[l];
        idx_q[l]    <= idx_d[l];
        acc_q[l]    <= acc_d[l];
        mem_q[l][0] <= mem_d[l][0];
        mem_q[l][1] <= mem_d[l][1];
        wr_q[l]     <= wr_d[l];
        rd_q[l]     <= rd_d[l];
        cnt_q[l]    <= cnt_d[l];
      end
    end
  end

  // Unstriper pointer and registered outputs.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      exp_q    <= 1'b0;
      data_q   <= 32'd0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      exp_q    <= exp_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign active_out = active_q;

`ifdef PHY_RX_ERR_CNT_EN
  logic       err_ev_s [2];
  logic [1:0] err_inc_s;
  logic [8:0] err_sum_s;
  logic [7:0] err_q;
  logic [7:0] err_d;

  // Error events per lane (partial discard or dropped word), saturating sum.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      err_ev_s[l] = (state_q[l] == ACTIVE) && boundary_s[l] &&
                    ((is_com_s[l] && (idx_q[l] != 2'd0)) ||
                     (word_done_s[l] && !wr_en_s[l]));
    end
    err_inc_s = {1'b0, err_ev_s[0]} + {1'b0, err_ev_s[1]};
    err_sum_s = {1'b0, err_q} + {7'd0, err_inc_s};
    if (err_sum_s[8]) begin
      err_d = 8'hFF;
    end else begin
      err_d = err_sum_s[7:0];
    end
  end

  // Error counter register.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      err_q <= 8'd0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_phy_rx.sv
// -----------------------------------------------------------------------------
// tb_phy_rx : self-checking bench for phy_rx.
// Streams are described as byte lists per lane plus a bit offset; a byte-level
// reference model (alignment by whole bytes, word queues of depth 2, round
// robin draining) predicts valid/data/active/err after every clock edge.
// -----------------------------------------------------------------------------
module tb_phy_rx;

  localparam logic [7:0] COM  = 8'hBC;
  localparam int         SYNC = 4;

  logic        clk_32f;
  logic        reset_L;
  logic        serial_in_0;
  logic        serial_in_1;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active_out;
`ifdef PHY_RX_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  int         n_total;
  int         n_bad;
  string      scn;
  logic [7:0] lb0[$];
  logic [7:0] lb1[$];

  phy_rx #(.COM_BYTE(COM), .SYNC_COUNT(SYNC)) dut (
    .clk_32f     (clk_32f),
    .reset_L     (reset_L),
    .serial_in_0 (serial_in_0),
    .serial_in_1 (serial_in_1),
`ifdef PHY_RX_ERR_CNT_EN
    .err_count   (err_count),
`endif
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active_out  (active_out)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s [%s] got=%h exp=%h at %0t", tag, scn, got, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_valid"},  {31'd0, valid_out},  32'd0);
    check_eq({tag, "_data"},   data_out,            32'd0);
    check_eq({tag, "_active"}, {31'd0, active_out}, 32'd0);
`ifdef PHY_RX_ERR_CNT_EN
    check_eq({tag, "_err"},    {24'd0, err_count},  32'd0);
`endif
  endtask

  task automatic push_byte(input int l, input logic [7:0] b);
    if (l == 0) lb0.push_back(b);
    else        lb1.push_back(b);
  endtask

  task automatic push_com(input int l, input int n);
    repeat (n) push_byte(l, COM);
  endtask

  task automatic push_word(input int l, input logic [31:0] w);
    for (int k = 3; k >= 0; k--) push_byte(l, w[8*k +: 8]);
  endtask

  function automatic logic [7:0] rand_data();
    logic [7:0] b;
    b = 8'($urandom);
    while (b == COM) b = 8'($urandom);
    return b;
  endfunction

  function automatic logic bit_of(input int l, input int t, input int off);
    int         i;
    logic [7:0] by;
    if (t < off) return 1'b0;
    i  = t - off;
    by = (l == 0) ? lb0[i/8] : lb1[i/8];
    return by[7 - (i % 8)];
  endfunction

  // Reset, then stream both byte lists and compare against the byte-level
  // model after every edge. stop_at >= 0 returns right after that edge's check.
  task automatic run_scn(input string name, input int off0, input int off1, input int stop_at);
    int          off[2];
    int          st[2];
    int          cnt[2];
    int          pend[2];
    logic [31:0] acc[2];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          expl;
    int          err;
    int          n;
    int          i;
    logic [31:0] exp_data;
    logic        exp_v;
    logic        exp_act;
    logic        done;
    logic [7:0]  b;

    scn    = name;
    off[0] = off0;
    off[1] = off1;
    n = off0 + 8 * lb0.size();
    if (off1 + 8 * lb1.size() > n) n = off1 + 8 * lb1.size();
    n = n + 40;
    while (off0 + 8 * lb0.size() < n) lb0.push_back(COM);
    while (off1 + 8 * lb1.size() < n) lb1.push_back(COM);

    reset_L     = 1'b0;
    serial_in_0 = 1'b0;
    serial_in_1 = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    check_outputs_zero("rst");
    @(negedge clk_32f);
    reset_L = 1'b1;

    for (int l = 0; l < 2; l++) begin
      st[l] = 0; cnt[l] = 0; pend[l] = 0; acc[l] = 32'd0;
    end
    expl = 0; err = 0; exp_data = 32'd0;

    for (int t = 0; t < n; t++) begin
      serial_in_0 = bit_of(0, t, off0);
      serial_in_1 = bit_of(1, t, off1);
      @(posedge clk_32f);
      #1;
      exp_act = (st[0] == 2) && (st[1] == 2);
      exp_v   = 1'b0;
      if (expl == 0) begin
        if (q0.size() > 0) begin exp_data = q0.pop_front(); exp_v = 1'b1; expl = 1; end
      end else begin
        if (q1.size() > 0) begin exp_data = q1.pop_front(); exp_v = 1'b1; expl = 0; end
      end
      for (int l = 0; l < 2; l++) begin
        i = t - off[l];
        if (i >= 0 && (i % 8) == 7) begin
          b    = (l == 0) ? lb0[i/8] : lb1[i/8];
          done = 1'b0;
          case (st[l])
            0: if (b == COM) begin st[l] = 1; cnt[l] = 1; end
            1: begin
              if (b == COM) begin
                cnt[l]++;
                if (cnt[l] == SYNC) st[l] = 2;
              end else begin
                cnt[l] = 0; st[l] = 0;
              end
            end
            default: begin
              if (b == COM) begin
                if (pend[l] != 0) err++;
                pend[l] = 0;
              end else begin
                acc[l] = {acc[l][23:0], b};
                pend[l]++;
                if (pend[l] == 4) begin done = 1'b1; pend[l] = 0; end
              end
            end
          endcase
          if (done) begin
            if (l == 0) begin
              if (q0.size() < 2) q0.push_back(acc[l]); else err++;
            end else begin
              if (q1.size() < 2) q1.push_back(acc[l]); else err++;
            end
          end
        end
      end
      check_eq("valid",  {31'd0, valid_out},  {31'd0, exp_v});
      check_eq("data",   data_out,            exp_data);
      check_eq("active", {31'd0, active_out}, {31'd0, exp_act});
`ifdef PHY_RX_ERR_CNT_EN
      check_eq("err",    {24'd0, err_count},  (err > 255) ? 32'd255 : 32'(err));
`endif
      if (stop_at >= 0 && t == stop_at) break;
      @(negedge clk_32f);
    end
  endtask

  task automatic clear_lists();
    lb0.delete();
    lb1.delete();
  endtask

  initial begin
    int o0;
    int o1;
    int nb;
    n_total     = 0;
    n_bad       = 0;
    scn         = "init";
    reset_L     = 1'b0;
    serial_in_0 = 1'b0;
    serial_in_1 = 1'b0;

    // Alignment only: commas at offset 3, no data.
    clear_lists();
    push_com(0, 8); push_com(1, 8);
    run_scn("align", 3, 3, -1);

    // Simultaneous words, lane 0 first.
    clear_lists();
    push_com(0, 4); push_word(0, 32'h01020304);
    push_com(1, 4); push_word(1, 32'hA0B0C0D0);
    run_scn("unstripe", 3, 3, -1);

    // Lane 1 leads lane 0 by 16 bits.
    clear_lists();
    push_com(0, 4); push_word(0, 32'h11111111);
    push_com(1, 4); push_word(1, 32'h22222222);
    run_scn("skew", 19, 3, -1);

    // Lane 1 overflows while lane 0 is still idle; lane 1 never jumps ahead.
    clear_lists();
    push_com(0, 20); push_word(0, 32'hCAFEF00D);
    push_com(1, 4);
    push_word(1, 32'h0A0B0C0D); push_word(1, 32'h1A1B1C1D); push_word(1, 32'h2A2B2C2D);
    run_scn("ovf", 0, 0, -1);

    // Reset asynchronously in the middle of a word.
    clear_lists();
    push_com(0, 4); push_word(0, 32'h01020304); push_byte(0, 8'h55); push_byte(0, 8'h66);
    push_com(1, 4); push_word(1, 32'hA0B0C0D0); push_byte(1, 8'h55); push_byte(1, 8'h66);
    run_scn("mid_reset", 3, 3, 3 + 8 * 10 + 3);
    #2;
    reset_L = 1'b0;
    #1;
    check_outputs_zero("async_rst");

    // Three commas then a data byte: back to search, a full run is needed.
    clear_lists();
    for (int l = 0; l < 2; l++) begin
      push_com(l, 3); push_byte(l, 8'h55); push_com(l, 4);
    end
    push_word(0, 32'h5A5A1234); push_word(1, 32'h89ABCDEF);
    run_scn("false_sync", 5, 2, -1);

    // Repeated partial words on lane 0: error counter saturates.
    clear_lists();
    push_com(0, 4);
    repeat (300) begin push_byte(0, 8'h12); push_byte(0, 8'h34); push_byte(0, COM); end
    push_com(1, 4);
    run_scn("err_sat", 0, 0, -1);

    // Randomized skews, data, idles and partial words.
    for (int r = 0; r < 6; r++) begin
      clear_lists();
      o0 = int'($urandom_range(0, 40));
      o1 = int'($urandom_range(0, 40));
      for (int l = 0; l < 2; l++) begin
        push_com(l, 4);
        nb = int'($urandom_range(12, 60));
        repeat (nb) begin
          if ($urandom_range(0, 5) == 0) push_byte(l, COM);
          else                           push_byte(l, rand_data());
        end
      end
      run_scn($sformatf("rand%0d", r), o0, o1, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
